// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator: owns the matrix RAM slot table, hands out base addresses with
// per-dimension oldest-first replacement, and resolves (m, n, idx) lookups.
module matrix_slot_allocator #(
  parameter int NUM_SLOTS   = 20,
  parameter int SLOT_WORDS  = 25,
  parameter int MAX_PER_DIM = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [2:0]        alloc_m,
  input  logic [2:0]        alloc_n,
  output logic              alloc_ready,
  output logic              alloc_fail,
  output logic [ADDR_W-1:0] base_addr,
  input  logic              commit,
  input  logic              abort,
  input  logic              query_req,
  input  logic [2:0]        query_m,
  input  logic [2:0]        query_n,
  input  logic [1:0]        query_idx,
  output logic              query_valid,
  output logic              query_hit,
  output logic [ADDR_W-1:0] query_addr,
  output logic [1:0]        dim_count,
  output logic [4:0]        total_count,
  output logic              busy
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);
  localparam logic [1:0] TOP_ORD = 2'(MAX_PER_DIM - 1);
  localparam logic [1:0] MAXC = 2'(MAX_PER_DIM);
  if (NUM_SLOTS * SLOT_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("ADDR_W too small for NUM_SLOTS*SLOT_WORDS");
  end
  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, PENDING, COMMIT, QSCAN} state_t;
  state_t state_q, state_d;
  logic tv_q [NUM_SLOTS];
  logic [2:0] tm_q [NUM_SLOTS];
  logic [2:0] tn_q [NUM_SLOTS];
  logic [1:0] to_q [NUM_SLOTS];
  logic [2:0] m_q, m_d, n_q, n_d;
  logic [1:0] qidx_q, qidx_d, cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, vic_idx_q, vic_idx_d, free_idx_q, free_idx_d, tgt_q, tgt_d;
  logic [ADDR_W-1:0] acc_q, acc_d, vic_addr_q, vic_addr_d, free_addr_q, free_addr_d;
  logic [ADDR_W-1:0] hit_addr_q, hit_addr_d, base_q, base_d, qaddr_q, qaddr_d;
  logic free_found_q, free_found_d, hit_q, hit_d, repl_q, repl_d;
  logic ready_q, ready_d, fail_q, fail_d, qvalid_q, qvalid_d, qhit_q, qhit_d;
  logic [1:0] dc_q, dc_d;
  logic [4:0] total_q, total_d;
  logic dims_ok, last, cur_match, append_ok, replace_ok, tbl_we;
  logic [1:0] wr_ord;
  assign dims_ok = alloc_m != 3'd0 && alloc_m <= 3'd5 && alloc_n != 3'd0 && alloc_n <= 3'd5;
  assign last = idx_q == LAST;
  assign cur_match = tv_q[idx_q] && tm_q[idx_q] == m_q && tn_q[idx_q] == n_q;
  assign append_ok = cnt_q < MAXC && free_found_q;
  assign replace_ok = cnt_q == MAXC;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = alloc_req ? (dims_ok ? SCAN : IDLE) : (query_req ? QSCAN : IDLE);
      SCAN:    state_d = last ? DECIDE : SCAN;
      DECIDE:  state_d = (append_ok || replace_ok) ? PENDING : IDLE;
      PENDING: state_d = abort ? IDLE : (commit ? COMMIT : PENDING);
      COMMIT:  state_d = last ? IDLE : COMMIT;
      QSCAN:   state_d = last ? IDLE : QSCAN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    {m_d, n_d, qidx_d, cnt_d, idx_d} = {m_q, n_q, qidx_q, cnt_q, idx_q};
    {vic_idx_d, vic_addr_d, free_idx_d, free_addr_d, free_found_d} =
      {vic_idx_q, vic_addr_q, free_idx_q, free_addr_q, free_found_q};
    {acc_d, hit_d, hit_addr_d, tgt_d, repl_d, base_d} = {acc_q, hit_q, hit_addr_q, tgt_q, repl_q, base_q};
    {qhit_d, qaddr_d, dc_d, total_d} = {qhit_q, qaddr_q, dc_q, total_q};
    {ready_d, fail_d, qvalid_d, tbl_we} = '0;
    wr_ord = (idx_q == tgt_q) ? (repl_q ? TOP_ORD : cnt_q) : to_q[idx_q] - 2'd1;
    case (state_q)
      IDLE: begin
        {cnt_d, idx_d, acc_d, free_found_d, hit_d, hit_addr_d} = '0;
        if (alloc_req) begin
          {m_d, n_d} = {alloc_m, alloc_n};
          fail_d = !dims_ok;
        end else if (query_req)
          {m_d, n_d, qidx_d} = {query_m, query_n, query_idx};
      end
      SCAN, QSCAN: begin
        idx_d = last ? '0 : idx_q + 1'b1;
        acc_d = acc_q + ADDR_W'(SLOT_WORDS);
        cnt_d = cur_match ? cnt_q + 2'd1 : cnt_q;
        if (state_q == SCAN) begin
          if (cur_match && to_q[idx_q] == 2'd0) {vic_idx_d, vic_addr_d} = {idx_q, acc_q};
          if (!tv_q[idx_q] && !free_found_q) {free_found_d, free_idx_d, free_addr_d} = {1'b1, idx_q, acc_q};
        end else begin
          if (cur_match && to_q[idx_q] == qidx_q) {hit_d, hit_addr_d} = {1'b1, acc_q};
          if (last) {qvalid_d, qhit_d, qaddr_d, dc_d} = {1'b1, hit_d, hit_addr_d, cnt_d};
        end
      end
      DECIDE: begin
        dc_d = cnt_q;
        idx_d = '0;
        if (append_ok) {tgt_d, base_d, repl_d, ready_d} = {free_idx_q, free_addr_q, 1'b0, 1'b1};
        else if (replace_ok) {tgt_d, base_d, repl_d, ready_d} = {vic_idx_q, vic_addr_q, 1'b1, 1'b1};
        else fail_d = 1'b1;
      end
      COMMIT: begin
        idx_d = last ? '0 : idx_q + 1'b1;
        tbl_we = idx_q == tgt_q || (repl_q && cur_match);
        if (last && !repl_q) total_d = total_q + 5'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tv_q <= '{default: 1'b0};
      tm_q <= '{default: 3'd0};
      tn_q <= '{default: 3'd0};
      to_q <= '{default: 2'd0};
    end else if (tbl_we) begin
      tv_q[idx_q] <= 1'b1;
      tm_q[idx_q] <= m_q;
      tn_q[idx_q] <= n_q;
      to_q[idx_q] <= wr_ord;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {m_q, n_q, qidx_q, cnt_q, idx_q} <= '0;
      {vic_idx_q, vic_addr_q, free_idx_q, free_addr_q, free_found_q} <= '0;
      {acc_q, hit_q, hit_addr_q, tgt_q, repl_q, base_q} <= '0;
      {qhit_q, qaddr_q, dc_q, total_q, ready_q, fail_q, qvalid_q} <= '0;
    end else begin
      {m_q, n_q, qidx_q, cnt_q, idx_q} <= {m_d, n_d, qidx_d, cnt_d, idx_d};
      {vic_idx_q, vic_addr_q, free_idx_q, free_addr_q, free_found_q} <=
        {vic_idx_d, vic_addr_d, free_idx_d, free_addr_d, free_found_d};
      {acc_q, hit_q, hit_addr_q, tgt_q, repl_q, base_q} <= {acc_d, hit_d, hit_addr_d, tgt_d, repl_d, base_d};
      {qhit_q, qaddr_q, dc_q, total_q, ready_q, fail_q, qvalid_q} <=
        {qhit_d, qaddr_d, dc_d, total_d, ready_d, fail_d, qvalid_d};
    end
  assign alloc_ready = ready_q;
  assign alloc_fail = fail_q;
  assign base_addr = base_q;
  assign query_valid = qvalid_q;
  assign query_hit = qhit_q;
  assign query_addr = qaddr_q;
  assign dim_count = dc_q;
  assign total_count = total_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_matrix_slot_allocator.sv
// tb_matrix_slot_allocator: directed vector table plus hand sequences for fill, abort and reset.
module tb_matrix_slot_allocator;
  logic clk = 0, rst = 1;
  logic alloc_req = 0, commit = 0, abort = 0, query_req = 0;
  logic [2:0] alloc_m = 0, alloc_n = 0, query_m = 0, query_n = 0;
  logic [1:0] query_idx = 0;
  logic alloc_ready, alloc_fail, query_valid, query_hit, busy;
  logic [8:0] base_addr, query_addr;
  logic [1:0] dim_count;
  logic [4:0] total_count;
  int n_tests = 0, n_fail = 0;

  matrix_slot_allocator dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
    .alloc_ready(alloc_ready), .alloc_fail(alloc_fail), .base_addr(base_addr),
    .commit(commit), .abort(abort), .query_req(query_req), .query_m(query_m),
    .query_n(query_n), .query_idx(query_idx), .query_valid(query_valid),
    .query_hit(query_hit), .query_addr(query_addr), .dim_count(dim_count),
    .total_count(total_count), .busy(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit is_q; logic [2:0] m, n; logic [1:0] idx; bit abrt;
    bit exp_ok; int exp_lat; int exp_addr; int exp_dc; int exp_total;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_alloc(input logic [2:0] m, input logic [2:0] n, output bit ok,
                          output int lat, output int addr, output bit bsy);
    @(negedge clk); alloc_req = 1; alloc_m = m; alloc_n = n;
    @(negedge clk); alloc_req = 0; lat = 1;
    while (!alloc_ready && !alloc_fail && lat < 60) begin @(negedge clk); lat++; end
    ok = alloc_ready; addr = base_addr; bsy = busy;
  endtask

  task automatic do_query(input logic [2:0] m, input logic [2:0] n, input logic [1:0] idx,
                          output bit hit, output int lat, output int addr, output int dc);
    @(negedge clk); query_req = 1; query_m = m; query_n = n; query_idx = idx;
    @(negedge clk); query_req = 0; lat = 1;
    while (!query_valid && lat < 60) begin @(negedge clk); lat++; end
    hit = query_hit; addr = query_addr; dc = dim_count;
  endtask

  task automatic finish_alloc(input bit abrt);
    int k;
    @(negedge clk); commit = !abrt; abort = abrt;
    @(negedge clk); commit = 0; abort = 0; k = 0;
    while (busy && k < 60) begin @(negedge clk); k++; end
    chk("finish_idle", int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, int'({alloc_ready, alloc_fail, query_valid, query_hit, busy}), 0);
    chk({tag, "_addrs"}, int'(base_addr) + int'(query_addr), 0);
    chk({tag, "_counts"}, int'(dim_count) + int'(total_count), 0);
  endtask

  initial begin
    bit ok, bsy;
    int lat, addr, dc;
    v[0]  = '{0, 3, 3, 0, 0, 1, 22, 0, 0, 1};
    v[1]  = '{1, 3, 3, 0, 0, 1, 21, 0, 1, 1};
    v[2]  = '{0, 2, 2, 0, 0, 1, 22, 25, 0, 2};
    v[3]  = '{0, 2, 2, 0, 0, 1, 22, 50, 0, 3};
    v[4]  = '{0, 2, 2, 0, 0, 1, 22, 25, 0, 3};
    v[5]  = '{1, 2, 2, 0, 0, 1, 21, 50, 2, 3};
    v[6]  = '{1, 2, 2, 1, 0, 1, 21, 25, 2, 3};
    v[7]  = '{0, 6, 2, 0, 0, 0, 1, 25, 0, 3};
    v[8]  = '{0, 4, 4, 0, 1, 1, 22, 75, 0, 3};
    v[9]  = '{0, 4, 4, 0, 0, 1, 22, 75, 0, 4};
    v[10] = '{1, 4, 4, 2, 0, 0, 21, 0, 1, 4};
    v[11] = '{1, 0, 3, 0, 0, 0, 21, 0, 0, 4};
    v[12] = '{1, 3, 3, 0, 0, 1, 21, 0, 1, 4};
    v[13] = '{0, 3, 0, 0, 0, 0, 1, 75, 0, 4};
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;
    for (int i = 0; i < 14; i++) begin
      if (v[i].is_q) begin
        do_query(v[i].m, v[i].n, v[i].idx, ok, lat, addr, dc);
        chk($sformatf("v%0d_dc", i), dc, v[i].exp_dc);
      end else begin
        do_alloc(v[i].m, v[i].n, ok, lat, addr, bsy);
        if (ok) finish_alloc(v[i].abrt);
        else chk($sformatf("v%0d_busy", i), int'(bsy), 0);
      end
      chk($sformatf("v%0d_ok", i), int'(ok), int'(v[i].exp_ok));
      chk($sformatf("v%0d_lat", i), lat, v[i].exp_lat);
      chk($sformatf("v%0d_addr", i), addr, v[i].exp_addr);
      chk($sformatf("v%0d_total", i), int'(total_count), v[i].exp_total);
    end
    // commit and abort together: abort must win, so the block is idle one cycle later
    do_alloc(5, 5, ok, lat, addr, bsy);
    chk("ca_addr", addr, 100);
    @(negedge clk); commit = 1; abort = 1;
    @(negedge clk); commit = 0; abort = 0;
    chk("ca_busy", int'(busy), 0);
    chk("ca_total", int'(total_count), 4);
    // fill all slots with 10 dimensions x2
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    for (int d = 0; d < 10; d++)
      for (int k = 0; k < 2; k++) begin
        do_alloc(3'(1 + d / 5), 3'(1 + d % 5), ok, lat, addr, bsy);
        chk($sformatf("fill%0d_addr", 2 * d + k), addr, (2 * d + k) * 25);
        finish_alloc(0);
      end
    chk("fill_total", int'(total_count), 20);
    do_alloc(5, 1, ok, lat, addr, bsy);
    chk("full_newdim_fail", int'(alloc_fail), 1);
    chk("full_newdim_lat", lat, 22);
    do_alloc(1, 1, ok, lat, addr, bsy);
    chk("full_repl_ok", int'(ok), 1);
    chk("full_repl_addr", addr, 0);
    finish_alloc(0);
    chk("full_repl_total", int'(total_count), 20);
    do_query(1, 1, 0, ok, lat, addr, dc);
    chk("full_q0_addr", addr, 25);
    do_query(1, 1, 1, ok, lat, addr, dc);
    chk("full_q1_addr", addr, 0);
    chk("full_q1_dc", dc, 2);
    // reset while a reservation is pending
    do_alloc(2, 3, ok, lat, addr, bsy);
    chk("pend_ok", int'(ok), 1);
    @(negedge clk); rst = 1; #1;
    chk_all_zero("midrst");
    @(negedge clk); rst = 0;
    do_query(2, 3, 0, ok, lat, addr, dc);
    chk("post_rst_hit", int'(ok), 0);
    chk("post_rst_total", int'(total_count), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_slot_allocator.md
Name: matrix_slot_allocator

Overview:
- Owns the matrix RAM's slot table.
- Hands the input subsystem a base address for each new matrix: drives its base-address and address-ready inputs.
- Tracks how many matrices of each dimension are stored and replaces the oldest matrix of a dimension when that dimension's limit is reached.
- Resolves (m, n, index) lookups to base addresses for the display and compute stages.

Parameters:
- NUM_SLOTS, 20, number of matrix slots in RAM.
- SLOT_WORDS, 25, words per slot (5x5 max).
- MAX_PER_DIM, 2, max stored matrices per (m,n) pair.
- ADDR_W, 9, RAM address width. NUM_SLOTS*SLOT_WORDS must be <= 2^ADDR_W, checked at elaboration.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- alloc_req  in  1  one-cycle pulse: request a slot for dimension alloc_m x alloc_n
- alloc_m  in  3  rows, legal 1..5
- alloc_n  in  3  cols, legal 1..5
- alloc_ready  out  1  one-cycle pulse: base_addr valid, slot tentatively reserved
- alloc_fail  out  1  one-cycle pulse: request rejected
- base_addr  out  ADDR_W  reserved slot base; held until next allocation
- commit  in  1  pulse: matrix fully written, make reservation permanent
- abort  in  1  pulse: discard reservation
- query_req  in  1  pulse: look up query_m, query_n, query_idx
- query_m  in  3  rows
- query_n  in  3  cols
- query_idx  in  2  0 = oldest of that dimension
- query_valid  out  1  one-cycle pulse: query result ready
- query_hit  out  1  entry exists
- query_addr  out  ADDR_W  its base (0 on miss)
- dim_count  out  2  matching-dimension count from last scan
- total_count  out  5  valid slots in table
- busy  out  1  high in every state except IDLE

Behaviour:
- Table per slot: valid, m[2:0], n[2:0], ord (0..MAX_PER_DIM-1, insertion order within dimension).
- Reset: table invalid; all outputs 0; state IDLE.
- States: IDLE, SCAN, DECIDE, PENDING, COMMIT, QSCAN.
- Requests arriving while busy=1 are ignored. Simultaneous alloc_req and query_req in IDLE: alloc wins, query dropped.

IDLE:
- On alloc_req, latch m/n.
- If m or n is outside 1..5: alloc_fail next cycle, stay IDLE.
- Otherwise go to SCAN.

SCAN (one slot per cycle, NUM_SLOTS cycles):
- Count valid matching entries.
- Record the slot with ord=0 among matches as victim.
- Record the lowest-index invalid slot.
- Accumulate slot*SLOT_WORDS by adding SLOT_WORDS each step. No multiplier.

DECIDE (1 cycle):
- If count < MAX_PER_DIM and a free slot exists: target = free slot, mode = append.
- Else if count == MAX_PER_DIM: target = victim, mode = replace.
- Else (pool full, dimension not full): alloc_fail, go to IDLE.
- On success: base_addr = target base, alloc_ready pulses, go to PENDING.
- alloc_ready is asserted exactly NUM_SLOTS+2 cycles after the alloc_req cycle.

PENDING:
- Table unchanged. Waits indefinitely.
- abort: go to IDLE, no table change.
- commit: go to COMMIT.
- commit and abort in the same cycle: abort wins.

COMMIT (NUM_SLOTS cycles):
- append: target gets valid=1, m, n, ord=count.
- replace: every other match has ord decremented; target is rewritten with ord=MAX_PER_DIM-1.
- total_count updates on the last cycle. Then go to IDLE.

QSCAN:
- Entered from IDLE on query_req. Runs NUM_SLOTS cycles.
- Finds a valid entry with matching m/n and ord==query_idx.
- Pulses query_valid NUM_SLOTS+1 cycles after query_req, with query_hit/query_addr.
- dim_count updates.
- Out-of-range dimension or query_idx >= MAX_PER_DIM: miss, addr 0.

Reset mid-operation: asynchronously clears table and reservation; any pending commit is lost.

Test Plan:
- Reset, alloc_req 3x3 -> alloc_ready at +22 cycles, base_addr=0; commit; total_count=1; query 3x3 idx0 -> hit, addr 0.
- Alloc 2x2 three times with commits -> bases 25, 50, then 25 again (replace). Query 2x2 idx0 -> addr 50; idx1 -> addr 25; dim_count=2.
- alloc_req 6x2 -> alloc_fail at +1 cycle, busy stays 0, table unchanged.
- Alloc 4x4 (base 75), abort -> total_count unchanged. Next alloc 4x4 returns 75 again.
- Fill all 20 slots with 10 distinct dimensions x2, then alloc a new dimension 5x1 -> alloc_fail. Alloc an existing dimension -> succeeds via replace.
- Assert rst during PENDING -> all outputs 0, total_count 0, later query misses.
